// File: rtl/ram16k_arbiter_pkg.sv
// Shared constants for the 16K x 16 RAM arbiter: geometry and FSM encoding.
package ram16k_arbiter_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/ram16k_arbiter_if.sv
// One requester port of the RAM arbiter: request/ack handshake plus address and data.
interface ram16k_arbiter_if
  import ram16k_arbiter_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DATA_W
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/ram16k_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; last pointer records the port granted most recently.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
    gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (en_i && (|req_i)) begin
      last_d = gnt_o[1];
    end
  end

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram16k_arbiter.sv
// Two-port arbiter/sequencer for the 16K x 16 RAM; one registered access every 3 cycles.
module ram16k_arbiter
  import ram16k_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ram16k_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram16k_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  ram16k_arbiter_if.slave   p0,
  ram16k_arbiter_if.slave   p1,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_out
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              en_q, en_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        gnt;
  logic              gnt_en;

  assign gnt_en = (state_q == ST_IDLE);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i ({p1.req, p0.req}),
    .en_i  (gnt_en),
    .gnt_o (gnt)
  );

  // Next state; mem_* are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    add_d    = add_q;
    in_d     = in_q;
    en_d     = 1'b0;
    read_d   = 1'b0;
    write_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (p0.req || p1.req) begin
          state_d = ST_ACCESS;
          sel_d   = gnt[1];
          we_d    = gnt[1] ? p1.we    : p0.we;
          add_d   = gnt[1] ? p1.addr  : p0.addr;
          in_d    = gnt[1] ? p1.wdata : p0.wdata;
          en_d    = 1'b1;
          read_d  = ~we_d;
          write_d = we_d;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        ack0_d  = ~sel_q;
        ack1_d  = sel_q;
        if (!we_q) begin
          if (sel_q) begin
            rdata1_d = mem_out;
          end else begin
            rdata0_d = mem_out;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      add_q    <= '0;
      in_q     <= '0;
      en_q     <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      add_q    <= add_d;
      in_q     <= in_d;
      en_q     <= en_d;
      read_q   <= read_d;
      write_q  <= write_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_add   = add_q;
  assign mem_in    = in_q;
  assign mem_en    = en_q;
  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign p0.ack    = ack0_q;
  assign p1.ack    = ack1_q;
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;

endmodule
